// File: rtl/commit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : commit_pkg
// Brief    : Shared types for the TURTLE in-order commit stage: the queued
//            entry layout, the head-decision enum and store size codes.
// Revision : 1.0 - initial release
// ============================================================================
package commit_pkg;

    // Field widths of a queued entry. The commit_queue XLEN/EXC_W parameters
    // default to these values and must be kept equal to them.
    localparam int c_entry_xlen  = 32;
    localparam int c_entry_exc_w = 6;

    // Store size codes carried with a store
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // What the head entry does this cycle
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        COMMIT    = 2'd1,
        EXCEPTION = 2'd2,
        WAIT_FIFO = 2'd3
    } commit_state_e;

    typedef struct packed {
        logic [4:0]               rd;
        logic [c_entry_xlen-1:0]  rd_val;
        logic [c_entry_xlen-1:0]  inst_pc;
        logic [c_entry_xlen-1:0]  jump_pc;
        logic                     jump_valid;
        logic [c_entry_exc_w-1:0] exc_num;
        logic [c_entry_xlen-1:0]  exc_val;
        logic                     exc_valid;
        logic [c_entry_xlen-1:0]  st_addr;
        logic [c_entry_xlen-1:0]  st_val;
        logic [1:0]               st_size;
        logic                     st_valid;
    } commit_entry_t;

endpackage
`default_nettype wire

// File: rtl/commit_queue_buf.sv
`default_nettype none
// ============================================================================
// Module   : commit_queue_buf
// Brief    : Circular buffer of commit_entry_t with push, pop and a clear that
//            takes priority over both. Pointers wrap naturally; the count
//            carries one extra bit so full and empty are distinguishable.
// Revision : 1.0 - initial release
// ============================================================================
module commit_queue_buf
    import commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  commit_entry_t            i_entry,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output commit_entry_t            o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    commit_entry_t      r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;

    logic               w_do_push;
    logic               w_do_pop;

    // A clear discards both a same-cycle push and pop
    assign w_do_push = i_push && !o_full  && !i_clear;
    assign w_do_pop  = i_pop  && !o_empty && !i_clear;

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH[PTR_W:0]);
    // Head valid bit tracks count != 0 exactly
    assign o_empty = !r_valid[r_head];

    // Entry storage; cleared on reset so data outputs read as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    // Pointers, count and per-entry valid bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // head == tail only when empty or full, so the two valid-bit
            // updates never target the same entry
            if (w_do_push) begin
                r_tail          <= r_tail + 1'b1;
                r_valid[r_tail] <= 1'b1;
            end
            if (w_do_pop) begin
                r_head          <= r_head + 1'b1;
                r_valid[r_head] <= 1'b0;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : commit_queue
// Brief    : In-order commit stage. Queues executed results and each cycle
//            retires the head: register write, store push, exception or
//            jump redirect. Execute is backpressured with execute_ready.
//            Optional macro COMMIT_RETIRE_COUNT_EN adds a 64-bit
//            retire_count of non-faulting retirements.
// Revision : 1.0 - initial release
// ============================================================================
module commit_queue
    import commit_pkg::*;
#(
    parameter int XLEN  = c_entry_xlen,
    parameter int DEPTH = 4,
    parameter int EXC_W = c_entry_exc_w
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   execute_valid,
    output logic                   execute_ready,
    input  logic [4:0]             execute_rd,
    input  logic [XLEN-1:0]        execute_rd_val,
    input  logic [XLEN-1:0]        execute_inst_pc,
    input  logic [XLEN-1:0]        execute_jump_pc,
    input  logic                   execute_jump_valid,
    input  logic [EXC_W-1:0]       execute_exception_num,
    input  logic [XLEN-1:0]        execute_exception_val,
    input  logic                   execute_exception_valid,
    input  logic [XLEN-1:0]        execute_store_addr,
    input  logic [XLEN-1:0]        execute_store_val,
    input  logic [1:0]             execute_store_size,
    input  logic                   execute_store_valid,
    input  logic                   datafifo_full,
    output logic [XLEN-1:0]        datafifo_addr_out,
    output logic [XLEN-1:0]        datafifo_val_out,
    output logic [1:0]             datafifo_size_out,
    output logic                   datafifo_valid_out,
    output logic [EXC_W-1:0]       exception_num_out,
    output logic [XLEN-1:0]        exception_val_out,
    output logic [XLEN-1:0]        exception_pc_out,
    output logic                   exception_valid_out,
    output logic [4:0]             rd_out,
    output logic [XLEN-1:0]        rd_val_out,
    output logic                   rd_valid_out,
    output logic                   commit_valid,
    output logic                   execute_stall,
    output logic                   pipeline_flush,
    output logic [XLEN-1:0]        pipeline_pc,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef COMMIT_RETIRE_COUNT_EN
    ,
    output logic [63:0]            retire_count
`endif
);

    commit_entry_t               w_in_entry;
    commit_entry_t               w_head;
    commit_state_e               w_state;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(DEPTH):0]      w_count;

    // Pack the execute result into a queue entry
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.rd         = execute_rd;
        w_in_entry.rd_val     = execute_rd_val;
        w_in_entry.inst_pc    = execute_inst_pc;
        w_in_entry.jump_pc    = execute_jump_pc;
        w_in_entry.jump_valid = execute_jump_valid;
        w_in_entry.exc_num    = execute_exception_num;
        w_in_entry.exc_val    = execute_exception_val;
        w_in_entry.exc_valid  = execute_exception_valid;
        w_in_entry.st_addr    = execute_store_addr;
        w_in_entry.st_val     = execute_store_val;
        w_in_entry.st_size    = execute_store_size;
        w_in_entry.st_valid   = execute_store_valid;
    end

    // Ready depends only on occupancy; no ready-from-commit path
    assign execute_ready = !w_full;
    assign occupancy     = w_count;

    commit_queue_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (execute_valid),
        .i_entry (w_in_entry),
        .i_pop   (commit_valid),
        .i_clear (pipeline_flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head decision in priority order
    always_comb begin
        w_state = COMMIT;
        if (w_empty) begin
            w_state = EMPTY;
        end else if (w_head.exc_valid) begin
            w_state = EXCEPTION;
        end else if (w_head.st_valid && datafifo_full) begin
            w_state = WAIT_FIFO;
        end
    end

    // Retirement outputs driven from the head entry
    always_comb begin
        datafifo_addr_out   = w_head.st_addr;
        datafifo_val_out    = w_head.st_val;
        datafifo_size_out   = w_head.st_size;
        exception_num_out   = w_head.exc_num;
        exception_val_out   = w_head.exc_val;
        exception_pc_out    = w_head.inst_pc;
        rd_out              = w_head.rd;
        rd_val_out          = w_head.rd_val;
        pipeline_pc         = w_head.jump_pc;
        datafifo_valid_out  = 1'b0;
        exception_valid_out = 1'b0;
        rd_valid_out        = 1'b0;
        commit_valid        = 1'b0;
        execute_stall       = 1'b0;
        pipeline_flush      = 1'b0;
        unique case (w_state)
            COMMIT: begin
                // A jump still writes its link register
                rd_valid_out       = (w_head.rd != 5'd0);
                datafifo_valid_out = w_head.st_valid;
                commit_valid       = 1'b1;
                pipeline_flush     = w_head.jump_valid;
            end
            EXCEPTION: begin
                exception_valid_out = 1'b1;
                commit_valid        = 1'b1;
                pipeline_flush      = 1'b1;
            end
            WAIT_FIFO: begin
                execute_stall = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef COMMIT_RETIRE_COUNT_EN
    logic [63:0] r_retire_count;

    // Count retired non-faulting instructions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_count <= '0;
        end else if (commit_valid && !exception_valid_out) begin
            r_retire_count <= r_retire_count + 64'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_queue
// Brief    : Directed self-checking bench for commit_queue (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_queue;
    import commit_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int EXC_W = 6;

    logic              clk;
    logic              reset;
    logic              execute_valid;
    logic              execute_ready;
    logic [4:0]        execute_rd;
    logic [XLEN-1:0]   execute_rd_val;
    logic [XLEN-1:0]   execute_inst_pc;
    logic [XLEN-1:0]   execute_jump_pc;
    logic              execute_jump_valid;
    logic [EXC_W-1:0]  execute_exception_num;
    logic [XLEN-1:0]   execute_exception_val;
    logic              execute_exception_valid;
    logic [XLEN-1:0]   execute_store_addr;
    logic [XLEN-1:0]   execute_store_val;
    logic [1:0]        execute_store_size;
    logic              execute_store_valid;
    logic              datafifo_full;
    logic [XLEN-1:0]   datafifo_addr_out;
    logic [XLEN-1:0]   datafifo_val_out;
    logic [1:0]        datafifo_size_out;
    logic              datafifo_valid_out;
    logic [EXC_W-1:0]  exception_num_out;
    logic [XLEN-1:0]   exception_val_out;
    logic [XLEN-1:0]   exception_pc_out;
    logic              exception_valid_out;
    logic [4:0]        rd_out;
    logic [XLEN-1:0]   rd_val_out;
    logic              rd_valid_out;
    logic              commit_valid;
    logic              execute_stall;
    logic              pipeline_flush;
    logic [XLEN-1:0]   pipeline_pc;
    logic [2:0]        occupancy;
`ifdef COMMIT_RETIRE_COUNT_EN
    logic [63:0]       retire_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    commit_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .EXC_W (EXC_W)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .execute_valid           (execute_valid),
        .execute_ready           (execute_ready),
        .execute_rd              (execute_rd),
        .execute_rd_val          (execute_rd_val),
        .execute_inst_pc         (execute_inst_pc),
        .execute_jump_pc         (execute_jump_pc),
        .execute_jump_valid      (execute_jump_valid),
        .execute_exception_num   (execute_exception_num),
        .execute_exception_val   (execute_exception_val),
        .execute_exception_valid (execute_exception_valid),
        .execute_store_addr      (execute_store_addr),
        .execute_store_val       (execute_store_val),
        .execute_store_size      (execute_store_size),
        .execute_store_valid     (execute_store_valid),
        .datafifo_full           (datafifo_full),
        .datafifo_addr_out       (datafifo_addr_out),
        .datafifo_val_out        (datafifo_val_out),
        .datafifo_size_out       (datafifo_size_out),
        .datafifo_valid_out      (datafifo_valid_out),
        .exception_num_out       (exception_num_out),
        .exception_val_out       (exception_val_out),
        .exception_pc_out        (exception_pc_out),
        .exception_valid_out     (exception_valid_out),
        .rd_out                  (rd_out),
        .rd_val_out              (rd_val_out),
        .rd_valid_out            (rd_valid_out),
        .commit_valid            (commit_valid),
        .execute_stall           (execute_stall),
        .pipeline_flush          (pipeline_flush),
        .pipeline_pc             (pipeline_pc),
        .occupancy               (occupancy)
`ifdef COMMIT_RETIRE_COUNT_EN
        ,
        .retire_count            (retire_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drop every execute-side input to an idle value
    task automatic clear_inputs();
        execute_valid           = 1'b0;
        execute_rd              = 5'd0;
        execute_rd_val          = '0;
        execute_inst_pc         = '0;
        execute_jump_pc         = '0;
        execute_jump_valid      = 1'b0;
        execute_exception_num   = '0;
        execute_exception_val   = '0;
        execute_exception_valid = 1'b0;
        execute_store_addr      = '0;
        execute_store_val       = '0;
        execute_store_size      = SZ_B;
        execute_store_valid     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        datafifo_full = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (execute_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", execute_ready);
        end
        n_checks++;
        if ({commit_valid, rd_valid_out, datafifo_valid_out, exception_valid_out, pipeline_flush, execute_stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 000000",
                     {commit_valid, rd_valid_out, datafifo_valid_out, exception_valid_out, pipeline_flush, execute_stall});
        end
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        n_checks++;
        if (rd_val_out !== 32'h0 || datafifo_addr_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got rd_val %h addr %h expected 0", rd_val_out, datafifo_addr_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_commit();
        @(negedge clk);
        clear_inputs();
        execute_valid   = 1'b1;
        execute_rd      = 5'd5;
        execute_rd_val  = 32'h1234;
        execute_inst_pc = 32'h100;
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({commit_valid, rd_valid_out, datafifo_valid_out, pipeline_flush} !== 4'b1100) begin
            n_fail++; $display("FAIL single_valids: got %b expected 1100",
                               {commit_valid, rd_valid_out, datafifo_valid_out, pipeline_flush});
        end
        n_checks++;
        if (rd_out !== 5'd5 || rd_val_out !== 32'h1234) begin
            n_fail++; $display("FAIL single_rd: got rd %0d val %h expected 5 1234", rd_out, rd_val_out);
        end
        n_checks++;
        if (occupancy !== 3'd1) begin
            n_fail++; $display("FAIL single_occ_head: got %0d expected 1", occupancy);
        end
        @(negedge clk);
        n_checks++;
        if (occupancy !== 3'd0 || commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got occ %0d commit %b expected 0 0", occupancy, commit_valid);
        end
    endtask

    task automatic test_store_wait();
        @(negedge clk);
        clear_inputs();
        datafifo_full       = 1'b1;
        execute_valid       = 1'b1;
        execute_inst_pc     = 32'h104;
        execute_store_valid = 1'b1;
        execute_store_addr  = 32'h2000;
        execute_store_val   = 32'hDEAD;
        execute_store_size  = SZ_W;
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({execute_stall, commit_valid, datafifo_valid_out} !== 3'b100 || occupancy !== 3'd1) begin
                n_fail++; $display("FAIL store_stall cycle %0d: got stall/commit/push %b occ %0d expected 100 1",
                                   c, {execute_stall, commit_valid, datafifo_valid_out}, occupancy);
            end
            @(negedge clk);
        end
        datafifo_full = 1'b0;
        #1;
        n_checks++;
        if ({datafifo_valid_out, commit_valid, execute_stall, rd_valid_out} !== 4'b1100) begin
            n_fail++; $display("FAIL store_push_valids: got %b expected 1100",
                               {datafifo_valid_out, commit_valid, execute_stall, rd_valid_out});
        end
        n_checks++;
        if (datafifo_addr_out !== 32'h2000 || datafifo_val_out !== 32'hDEAD || datafifo_size_out !== 2'd2) begin
            n_fail++; $display("FAIL store_push_data: got %h %h %0d expected 2000 dead 2",
                               datafifo_addr_out, datafifo_val_out, datafifo_size_out);
        end
        @(negedge clk);
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++; $display("FAIL store_drain: got %0d expected 0", occupancy);
        end
    endtask

    task automatic test_full_backpressure();
        logic exp_ready;
        @(negedge clk);
        clear_inputs();
        datafifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            execute_valid       = 1'b1;
            execute_store_valid = 1'b1;
            execute_inst_pc     = 32'h200 + 32'(4 * i);
            execute_store_addr  = 32'h200 + 32'(4 * i);
            execute_store_val   = 32'(i);
            execute_store_size  = SZ_W;
            #1;
            exp_ready = (i < 4);
            n_checks++;
            if (execute_ready !== exp_ready) begin
                n_fail++; $display("FAIL full_ready push %0d: got %b expected %b", i, execute_ready, exp_ready);
            end
            @(negedge clk);
        end
        n_checks++;
        if (occupancy !== 3'd4 || execute_ready !== 1'b0 || execute_stall !== 1'b1) begin
            n_fail++; $display("FAIL full_hold: got occ %0d ready %b stall %b expected 4 0 1",
                               occupancy, execute_ready, execute_stall);
        end
        datafifo_full = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) execute_valid = 1'b0;
            #1;
            n_checks++;
            if ({commit_valid, datafifo_valid_out} !== 2'b11 || datafifo_addr_out !== 32'h200 + 32'(4 * k)) begin
                n_fail++; $display("FAIL full_order %0d: got valids %b addr %h expected 11 %h",
                                   k, {commit_valid, datafifo_valid_out}, datafifo_addr_out, 32'h200 + 32'(4 * k));
            end
            if (k == 0) begin
                n_checks++;
                if (execute_ready !== 1'b0) begin
                    n_fail++; $display("FAIL full_ready_while_retire: got %b expected 0", execute_ready);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (execute_ready !== 1'b1) begin
                    n_fail++; $display("FAIL full_ready_after_retire: got %b expected 1", execute_ready);
                end
            end
            @(negedge clk);
        end
        clear_inputs();
        n_checks++;
        if (occupancy !== 3'd0) begin
            n_fail++; $display("FAIL full_drain: got %0d expected 0", occupancy);
        end
    endtask

    task automatic test_jump_flush();
        @(negedge clk);
        clear_inputs();
        datafifo_full       = 1'b1;
        execute_valid       = 1'b1;
        execute_inst_pc     = 32'h0C;
        execute_store_valid = 1'b1;
        execute_store_addr  = 32'h3000;
        @(negedge clk);
        clear_inputs();
        execute_valid      = 1'b1;
        execute_inst_pc    = 32'h10;
        execute_jump_valid = 1'b1;
        execute_jump_pc    = 32'h80;
        execute_rd         = 5'd1;
        execute_rd_val     = 32'h14;
        @(negedge clk);
        clear_inputs();
        execute_valid   = 1'b1;
        execute_inst_pc = 32'h14;
        execute_rd      = 5'd2;
        execute_rd_val  = 32'h22;
        @(negedge clk);
        clear_inputs();
        execute_valid   = 1'b1;
        execute_inst_pc = 32'h18;
        execute_rd      = 5'd3;
        execute_rd_val  = 32'h33;
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if (occupancy !== 3'd4) begin
            n_fail++; $display("FAIL jump_prefill: got %0d expected 4", occupancy);
        end
        datafifo_full = 1'b0;
        @(negedge clk);
        execute_valid   = 1'b1;
        execute_inst_pc = 32'h1C;
        execute_rd      = 5'd4;
        execute_rd_val  = 32'h44;
        #1;
        n_checks++;
        if ({commit_valid, rd_valid_out, pipeline_flush, datafifo_valid_out} !== 4'b1110) begin
            n_fail++; $display("FAIL jump_valids: got %b expected 1110",
                               {commit_valid, rd_valid_out, pipeline_flush, datafifo_valid_out});
        end
        n_checks++;
        if (rd_out !== 5'd1 || rd_val_out !== 32'h14 || pipeline_pc !== 32'h80) begin
            n_fail++; $display("FAIL jump_data: got rd %0d val %h pc %h expected 1 14 80", rd_out, rd_val_out, pipeline_pc);
        end
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if (occupancy !== 3'd0 || commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL jump_flushed: got occ %0d commit %b expected 0 0", occupancy, commit_valid);
        end
    endtask

    task automatic test_exception();
        @(negedge clk);
        clear_inputs();
        datafifo_full           = 1'b1;
        execute_valid           = 1'b1;
        execute_inst_pc         = 32'h300;
        execute_rd              = 5'd3;
        execute_rd_val          = 32'h55;
        execute_exception_valid = 1'b1;
        execute_exception_num   = 6'd2;
        execute_exception_val   = 32'hBAD;
        execute_store_valid     = 1'b1;
        execute_store_addr      = 32'h4000;
        @(negedge clk);
        clear_inputs();
        execute_valid   = 1'b1;
        execute_inst_pc = 32'h304;
        execute_rd      = 5'd6;
        execute_rd_val  = 32'h1;
        #1;
        n_checks++;
        if ({exception_valid_out, commit_valid, pipeline_flush} !== 3'b111 ||
            {datafifo_valid_out, rd_valid_out, execute_stall} !== 3'b000) begin
            n_fail++; $display("FAIL exc_valids: got %b %b expected 111 000",
                               {exception_valid_out, commit_valid, pipeline_flush},
                               {datafifo_valid_out, rd_valid_out, execute_stall});
        end
        n_checks++;
        if (exception_num_out !== 6'd2 || exception_val_out !== 32'hBAD || exception_pc_out !== 32'h300) begin
            n_fail++; $display("FAIL exc_data: got num %0d val %h pc %h expected 2 bad 300",
                               exception_num_out, exception_val_out, exception_pc_out);
        end
        @(negedge clk);
        clear_inputs();
        datafifo_full = 1'b0;
        n_checks++;
        if (occupancy !== 3'd0 || exception_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL exc_cleared: got occ %0d exc %b expected 0 0", occupancy, exception_valid_out);
        end
`ifdef COMMIT_RETIRE_COUNT_EN
        n_checks++;
        if (retire_count !== 64'd9) begin
            n_fail++; $display("FAIL retire_count: got %0d expected 9", retire_count);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        clear_inputs();
        datafifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            execute_valid       = 1'b1;
            execute_inst_pc     = 32'h500 + 32'(4 * i);
            execute_store_valid = 1'b1;
            execute_store_addr  = 32'h600 + 32'(4 * i);
            execute_rd          = 5'd7;
            @(negedge clk);
        end
        clear_inputs();
        n_checks++;
        if (occupancy !== 3'd3 || execute_stall !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got occ %0d stall %b expected 3 1", occupancy, execute_stall);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (occupancy !== 3'd0 || execute_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_async: got occ %0d ready %b expected 0 1", occupancy, execute_ready);
        end
        n_checks++;
        if ({execute_stall, commit_valid, datafifo_valid_out, exception_valid_out, pipeline_flush, rd_valid_out} !== 6'b0 ||
            datafifo_addr_out !== 32'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b addr %h expected 000000 0",
                               {execute_stall, commit_valid, datafifo_valid_out, exception_valid_out, pipeline_flush, rd_valid_out},
                               datafifo_addr_out);
        end
`ifdef COMMIT_RETIRE_COUNT_EN
        n_checks++;
        if (retire_count !== 64'd0) begin
            n_fail++; $display("FAIL retire_count_reset: got %0d expected 0", retire_count);
        end
`endif
        @(negedge clk);
        reset = 1'b1;
        datafifo_full = 1'b0;
        @(negedge clk);
        n_checks++;
        if (occupancy !== 3'd0 || execute_ready !== 1'b1 || commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_release: got occ %0d ready %b commit %b expected 0 1 0",
                               occupancy, execute_ready, commit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_store_wait();
        test_full_backpressure();
        test_jump_flush();
        test_exception();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
`default_nettype wire

// File: doc/commit_queue.md
Name: commit_queue

Overview:
- Parametrised in-order commit stage for the TURTLE pipeline. Sits between execute and the regfile, data FIFO and trap logic.
- Buffers up to DEPTH executed results in a circular queue and retires the head entry each cycle.
- At retirement it writes the register, pushes the store to the data FIFO, raises an exception, or redirects the pipeline on a jump.
- Backpressures execute with a ready signal instead of a single holding register.

Parameters:
- XLEN, 32, data/address width
- DEPTH, 4, queue entries; power of two, minimum 2
- EXC_W, 6, exception number width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- execute_valid  in  1  execute presents a result
- execute_ready  out  1  queue can accept; equals !full
- execute_rd  in  5  destination register
- execute_rd_val  in  XLEN  destination value
- execute_inst_pc  in  XLEN  instruction PC
- execute_jump_pc  in  XLEN  redirect target
- execute_jump_valid  in  1  instruction redirects the pipeline
- execute_exception_num  in  EXC_W  cause
- execute_exception_val  in  XLEN  trap value
- execute_exception_valid  in  1  instruction faulted
- execute_store_addr  in  XLEN  store address
- execute_store_val  in  XLEN  store data
- execute_store_size  in  2  store size code
- execute_store_valid  in  1  instruction is a store
- datafifo_full  in  1  data FIFO cannot accept
- datafifo_addr_out / datafifo_val_out  out  XLEN  store address/data from head
- datafifo_size_out  out  2  store size from head
- datafifo_valid_out  out  1  push store
- exception_num_out  out  EXC_W  head cause
- exception_val_out  out  XLEN  head trap value
- exception_pc_out  out  XLEN  head PC
- exception_valid_out  out  1  exception retired
- rd_out  out  5  head rd
- rd_val_out  out  XLEN  head rd value
- rd_valid_out  out  1  regfile write enable
- commit_valid  out  1  head retired this cycle
- execute_stall  out  1  head store blocked on FIFO
- pipeline_flush  out  1  flush upstream stages
- pipeline_pc  out  XLEN  redirect target (head jump PC)
- occupancy  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (async assert, sync release): head, tail and count are 0 and all entry valid bits clear.
  - Therefore every *_valid_out, commit_valid, pipeline_flush and execute_stall are 0; execute_ready is 1.
  - Data outputs are don't-care-but-stable; implement them as 0.
- Enqueue: when execute_valid && execute_ready, write all execute_* fields to entry[tail]; tail increments mod DEPTH. The entry is visible at the head no earlier than the next cycle (1-cycle minimum latency).
- Head decision is combinational, evaluated in priority order:
  - EMPTY: count == 0.
  - EXCEPTION: head exception_valid.
  - WAIT_FIFO: head store_valid && datafifo_full.
  - COMMIT: otherwise.
- COMMIT:
  - rd_valid_out = (rd != 0).
  - datafifo_valid_out = head store_valid.
  - commit_valid = 1.
  - If head jump_valid, also drive pipeline_flush = 1 and pipeline_pc = head jump_pc; a jump still writes rd (link register).
- EXCEPTION:
  - exception_valid_out = 1, commit_valid = 1, pipeline_flush = 1.
  - No rd write and no store push, even if the entry has rd or store_valid set.
- WAIT_FIFO: execute_stall = 1; nothing retires; the head is held until datafifo_full drops.
- Flush (any cycle with pipeline_flush = 1): on the clock edge all entries are invalidated and head = tail = count = 0.
  - An enqueue in the same cycle is discarded (upstream is being flushed).
- Simultaneous enqueue and retire without flush: count is unchanged, head and tail both advance.
- Full: execute_ready = 0 when count == DEPTH, even if the head retires that cycle. There is no combinational ready-from-commit path.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; count carries the extra bit to distinguish full from empty.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro COMMIT_RETIRE_COUNT_EN.
- Defined: adds output retire_count (64 bits, reset 0). It increments by 1 on every cycle with commit_valid && !exception_valid_out, i.e. retired non-faulting instructions (instret source), and wraps at 2^64.
- Undefined: the port and counter are absent.

Decomposition:
- Package commit_pkg holds:
  - the commit_entry_t struct (rd, rd_val, inst_pc, jump_pc, jump_valid, exc_num, exc_val, exc_valid, st_addr, st_val, st_size, st_valid);
  - the commit_state_e enum (EMPTY, COMMIT, EXCEPTION, WAIT_FIFO);
  - store size constants (SZ_B=0, SZ_H=1, SZ_W=2).
- One sub-module, commit_queue_buf: a circular buffer of commit_entry_t with push/pop/clear, count, full/empty. The top level contains the head decision logic only.

Test Plan:
- Reset, then enqueue rd=5 val=0x1234 pc=0x100 -> next cycle rd_valid_out=1, rd_out=5, rd_val_out=0x1234, commit_valid=1; occupancy returns to 0.
- Enqueue a store (addr=0x2000, val=0xDEAD, size=2) with datafifo_full=1 for 3 cycles -> execute_stall=1 and no retire for 3 cycles, then datafifo_valid_out=1 with addr 0x2000 on the cycle full drops.
- Hold the FIFO full and push 5 entries with DEPTH=4 -> execute_ready=0 after the 4th; the 5th is accepted only after the first retire; all 5 retire in PC order.
- Queue holds pc 0x10 (jump to 0x80, rd=1) plus two more entries, with execute_valid high during the jump's retire -> rd 1 written, pipeline_flush=1, pipeline_pc=0x80; occupancy=0 next cycle; the same-cycle enqueue is dropped.
- Head carries exception_valid with num=2, val=0xBAD, store_valid=1, rd=3 -> exception_valid_out=1, exception_pc_out=head pc; datafifo_valid_out=0, rd_valid_out=0; queue cleared.
- Assert reset (low) mid-stream while WAIT_FIFO with 3 entries queued -> all outputs drop immediately; after release occupancy=0 and execute_ready=1.
